// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg: shared FSM state type and address-split helpers
// Rev 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int INDEX_W_DEF = 6;
    localparam int TAG_W_DEF   = 30 - INDEX_W_DEF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_MISS = 2'd1,
        S_WR_THRU = 2'd2,
        S_WR_DONE = 2'd3
    } state_t;

    // Results are zero-extended to 32 bits; callers size-cast to their width.
    function automatic logic [31:0] get_index(input logic [31:0] byte_addr, input int iw);
        return (byte_addr >> 2) & ((32'd1 << iw) - 32'd1);
    endfunction

    function automatic logic [31:0] get_tag(input logic [31:0] byte_addr, input int iw);
        return byte_addr >> (iw + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_cache_ctrl_if.sv
`default_nettype none
// ============================================================================
// dmem_cache_ctrl_if: MEM-stage request bus plus backing-memory handshake
// Rev 1.0 - initial release
// ============================================================================
interface dmem_cache_ctrl_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic        stall;
    logic        bm_req;
    logic        bm_we;
    logic [31:0] bm_addr;
    logic [31:0] bm_wdata;
    logic        bm_ack;
    logic [31:0] bm_rdata;

    modport slave (
        input  mem_read, mem_write, addr, wdata, bm_ack, bm_rdata,
        output rdata, hit, stall, bm_req, bm_we, bm_addr, bm_wdata
    );

    modport master (
        output mem_read, mem_write, addr, wdata, bm_ack, bm_rdata,
        input  rdata, hit, stall, bm_req, bm_we, bm_addr, bm_wdata
    );
endinterface
`default_nettype wire

// File: rtl/dcache_line_array.sv
`default_nettype none
// ============================================================================
// dcache_line_array: valid/tag/data storage, async read, sync write and clear
// Rev 1.0 - initial release
// ============================================================================
module dcache_line_array #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 24
) (
    input  wire logic               clk,
    input  wire logic               clr,
    input  wire logic [INDEX_W-1:0] rd_index,
    output logic                    rd_valid,
    output logic [TAG_W-1:0]        rd_tag,
    output logic [31:0]             rd_data,
    input  wire logic               we,
    input  wire logic [INDEX_W-1:0] wr_index,
    input  wire logic [TAG_W-1:0]   wr_tag,
    input  wire logic [31:0]        wr_data,
    input  wire logic               wr_set_valid
);
    localparam int c_LINES = 1 << INDEX_W;

    logic [c_LINES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag  [c_LINES];
    logic [31:0]        r_data [c_LINES];

    // Clearing only the valid bits is enough to invalidate the whole array.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_valid <= '0;
        end else if (we) begin
            r_valid[wr_index] <= wr_set_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            r_tag[wr_index]  <= wr_tag;
            r_data[wr_index] <= wr_data;
        end
    end

    assign rd_valid = r_valid[rd_index];
    assign rd_tag   = r_tag[rd_index];
    assign rd_data  = r_data[rd_index];

endmodule
`default_nettype wire

// File: rtl/dmem_cache_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_cache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// Rev 1.0 - initial release
// ============================================================================
module dmem_cache_ctrl
    import dmem_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int CNT_W   = 16
) (
    input  wire logic      clk_50,
    input  wire logic      rst,
    dmem_cache_ctrl_if.slave bus,
    output logic [CNT_W-1:0] rd_hit_cnt,
    output logic [CNT_W-1:0] rd_miss_cnt
);
    localparam int c_TAG_W = 30 - INDEX_W;

    state_t r_state;
    state_t w_state_nxt;

    logic [29:0]        r_bm_word;
    logic [31:0]        r_bm_wdata;
    logic [31:0]        w_bm_addr;

    logic [INDEX_W-1:0] w_index;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_line_valid;
    logic [c_TAG_W-1:0] w_line_tag;
    logic [31:0]        w_line_data;
    logic               w_lookup_hit;

    logic               w_we;
    logic [INDEX_W-1:0] w_wr_index;
    logic [c_TAG_W-1:0] w_wr_tag;
    logic [31:0]        w_wr_data;
    logic               w_hit;
    logic               w_stall;
    logic               w_load_miss;

    assign w_index      = INDEX_W'(get_index(bus.addr, INDEX_W));
    assign w_tag        = c_TAG_W'(get_tag(bus.addr, INDEX_W));
    assign w_lookup_hit = w_line_valid && (w_line_tag == w_tag);
    assign w_bm_addr    = {r_bm_word, 2'b00};

    // Refills use the address latched at request time, IDLE store-hits use the live bus.
    assign w_wr_index = (r_state == S_IDLE) ? w_index : INDEX_W'(get_index(w_bm_addr, INDEX_W));
    assign w_wr_tag   = (r_state == S_IDLE) ? w_tag   : c_TAG_W'(get_tag(w_bm_addr, INDEX_W));

    dcache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (c_TAG_W)
    ) u_lines (
        .clk          (clk_50),
        .clr          (!rst),
        .rd_index     (w_index),
        .rd_valid     (w_line_valid),
        .rd_tag       (w_line_tag),
        .rd_data      (w_line_data),
        .we           (w_we),
        .wr_index     (w_wr_index),
        .wr_tag       (w_wr_tag),
        .wr_data      (w_wr_data),
        .wr_set_valid (1'b1)
    );

    always_ff @(posedge clk_50) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_hit       = 1'b0;
        w_we        = 1'b0;
        w_wr_data   = bus.wdata;
        w_load_miss = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.mem_write) begin
                    w_stall     = 1'b1;
                    w_we        = w_lookup_hit;
                    w_state_nxt = S_WR_THRU;
                end else if (bus.mem_read) begin
                    if (w_lookup_hit) begin
                        w_hit = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_load_miss = 1'b1;
                        w_state_nxt = S_RD_MISS;
                    end
                end
            end
            S_RD_MISS: begin
                w_stall = 1'b1;
                if (bus.bm_ack) begin
                    w_we        = 1'b1;
                    w_wr_data   = bus.bm_rdata;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_THRU: begin
                w_stall = 1'b1;
                if (bus.bm_ack) begin
                    w_state_nxt = S_WR_DONE;
                end
            end
            S_WR_DONE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Latched every IDLE cycle so the backing-memory request stays stable once issued.
    always_ff @(posedge clk_50) begin
        if (r_state == S_IDLE) begin
            r_bm_word  <= bus.addr[31:2];
            r_bm_wdata <= bus.wdata;
        end
    end

    always_ff @(posedge clk_50) begin
        if (!rst) begin
            rd_hit_cnt  <= '0;
            rd_miss_cnt <= '0;
        end else begin
            if (w_hit && (rd_hit_cnt != '1)) begin
                rd_hit_cnt <= rd_hit_cnt + 1'b1;
            end
            if (w_load_miss && (rd_miss_cnt != '1)) begin
                rd_miss_cnt <= rd_miss_cnt + 1'b1;
            end
        end
    end

    assign bus.hit      = w_hit;
    assign bus.stall    = w_stall;
    assign bus.rdata    = w_hit ? w_line_data : 32'd0;
    assign bus.bm_req   = (r_state == S_RD_MISS) || (r_state == S_WR_THRU);
    assign bus.bm_we    = (r_state == S_WR_THRU);
    assign bus.bm_addr  = w_bm_addr;
    assign bus.bm_wdata = r_bm_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_cache_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dmem_cache_ctrl: directed + random checks against a cache/memory map model
// Rev 1.0 - initial release
// ============================================================================
module tb_dmem_cache_ctrl;
    localparam int IW   = 6;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk_50 = 1'b0;
    logic rst    = 1'b0;
    always #5 clk_50 = ~clk_50;

    logic [CW-1:0] rd_hit_cnt;
    logic [CW-1:0] rd_miss_cnt;

    dmem_cache_ctrl_if bus ();

    dmem_cache_ctrl #(
        .INDEX_W (IW),
        .CNT_W   (CW)
    ) dut (
        .clk_50      (clk_50),
        .rst         (rst),
        .bus         (bus),
        .rd_hit_cnt  (rd_hit_cnt),
        .rd_miss_cnt (rd_miss_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference: what each cache line holds, plus the backing store contents.
    bit          m_valid [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_data  [64];
    logic [31:0] bmem    [logic [29:0]];
    int          exp_hits;
    int          exp_misses;

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    function automatic logic [31:0] bm_read(input logic [31:0] a);
        if (bmem.exists(a[31:2])) return bmem[a[31:2]];
        return {a[31:2], 2'b00} ^ 32'h5A3C_0F11;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[a[7:2]] && (m_tag[a[7:2]] == a[31:8]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic start_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk_50); #1;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.addr      = a;
        bus.wdata     = wd;
        bus.bm_ack    = 1'b0;
        bus.bm_rdata  = $urandom;
        @(negedge clk_50);
        check("rd_hit_cnt", 32'(rd_hit_cnt), 32'(exp_hits));
        check("rd_miss_cnt", 32'(rd_miss_cnt), 32'(exp_misses));
    endtask

    task automatic do_idle();
        start_op(1'b0, 1'b0, $urandom, $urandom);
        check("idle_hit", 32'(bus.hit), 32'd0);
        check("idle_stall", 32'(bus.stall), 32'd0);
        check("idle_rdata", bus.rdata, 32'd0);
        check("idle_bm_req", 32'(bus.bm_req), 32'd0);
    endtask

    task automatic do_load(input logic [31:0] a, input int d);
        bit          h;
        logic [31:0] v;
        h = model_hit(a);
        start_op(1'b1, 1'b0, a, $urandom);
        if (h) begin
            check("ld_hit", 32'(bus.hit), 32'd1);
            check("ld_hit_rdata", bus.rdata, m_data[a[7:2]]);
            check("ld_hit_stall", 32'(bus.stall), 32'd0);
            check("ld_hit_bm_req", 32'(bus.bm_req), 32'd0);
            exp_hits = sat(exp_hits + 1);
        end else begin
            check("ld_miss_stall", 32'(bus.stall), 32'd1);
            check("ld_miss_hit", 32'(bus.hit), 32'd0);
            check("ld_miss_rdata", bus.rdata, 32'd0);
            exp_misses = sat(exp_misses + 1);
            v = bm_read(a);
            for (int k = 0; k <= d; k++) begin
                @(posedge clk_50); #1;
                if (k == d) begin
                    bus.bm_ack   = 1'b1;
                    bus.bm_rdata = v;
                end else begin
                    bus.bm_rdata = $urandom;
                end
                @(negedge clk_50);
                check("rdm_bm_req", 32'(bus.bm_req), 32'd1);
                check("rdm_bm_we", 32'(bus.bm_we), 32'd0);
                check("rdm_bm_addr", bus.bm_addr, {a[31:2], 2'b00});
                check("rdm_stall", 32'(bus.stall), 32'd1);
                check("rdm_hit", 32'(bus.hit), 32'd0);
            end
            @(posedge clk_50); #1;
            bus.bm_ack = 1'b0;
            @(negedge clk_50);
            check("refill_hit", 32'(bus.hit), 32'd1);
            check("refill_rdata", bus.rdata, v);
            check("refill_stall", 32'(bus.stall), 32'd0);
            check("refill_bm_req", 32'(bus.bm_req), 32'd0);
            m_valid[a[7:2]] = 1'b1;
            m_tag[a[7:2]]   = a[31:8];
            m_data[a[7:2]]  = v;
            exp_hits = sat(exp_hits + 1);
        end
    endtask

    task automatic do_store(input logic rd, input logic [31:0] a, input logic [31:0] wd, input int d);
        start_op(rd, 1'b1, a, wd);
        check("st_stall", 32'(bus.stall), 32'd1);
        check("st_hit", 32'(bus.hit), 32'd0);
        check("st_rdata", bus.rdata, 32'd0);
        for (int k = 0; k <= d; k++) begin
            @(posedge clk_50); #1;
            bus.bm_ack = (k == d);
            @(negedge clk_50);
            check("wt_bm_req", 32'(bus.bm_req), 32'd1);
            check("wt_bm_we", 32'(bus.bm_we), 32'd1);
            check("wt_bm_addr", bus.bm_addr, {a[31:2], 2'b00});
            check("wt_bm_wdata", bus.bm_wdata, wd);
            check("wt_stall", 32'(bus.stall), 32'd1);
        end
        @(posedge clk_50); #1;
        bus.bm_ack = 1'b0;
        @(negedge clk_50);
        check("wdone_stall", 32'(bus.stall), 32'd0);
        check("wdone_hit", 32'(bus.hit), 32'd0);
        check("wdone_bm_req", 32'(bus.bm_req), 32'd0);
        bmem[a[31:2]] = wd;
        if (model_hit(a)) m_data[a[7:2]] = wd;
    endtask

    initial begin
        logic [31:0] ra;
        int          op;

        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr      = 32'd0;
        bus.wdata     = 32'd0;
        bus.bm_ack    = 1'b0;
        bus.bm_rdata  = 32'd0;
        model_reset();

        // Cold reset, then reset-state outputs.
        @(posedge clk_50); #1;
        rst = 1'b1;
        @(negedge clk_50);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_bm_req", 32'(bus.bm_req), 32'd0);
        check("rst_hit_cnt", 32'(rd_hit_cnt), 32'd0);
        check("rst_miss_cnt", 32'(rd_miss_cnt), 32'd0);

        // Cold load (4 stall cycles), repeat hit, conflict eviction.
        do_load(32'h100, 2);
        do_load(32'h100, 0);
        do_load(32'h1100, 1);
        do_load(32'h100, 0);

        // Store hit, no re-issued request, load sees new data.
        do_store(1'b0, 32'h100, 32'h1234_5678, 1);
        do_idle();
        do_load(32'h100, 0);

        // Store miss does not allocate.
        do_store(1'b0, 32'h200, 32'hCAFE_F00D, 0);
        do_load(32'h200, 1);

        // Reset mid-refill followed by a stray ack.
        start_op(1'b1, 1'b0, 32'h300, 32'd0);
        check("pre_rst_stall", 32'(bus.stall), 32'd1);
        @(posedge clk_50); #1;
        rst           = 1'b0;
        bus.mem_read  = 1'b0;
        @(negedge clk_50);
        check("pre_rst_bm_req", 32'(bus.bm_req), 32'd1);
        @(posedge clk_50); #1;
        rst          = 1'b1;
        bus.bm_ack   = 1'b1;
        bus.bm_rdata = 32'hBAD0_BAD0;
        model_reset();
        @(negedge clk_50);
        check("abort_bm_req", 32'(bus.bm_req), 32'd0);
        check("abort_stall", 32'(bus.stall), 32'd0);
        check("abort_hit_cnt", 32'(rd_hit_cnt), 32'd0);
        check("abort_miss_cnt", 32'(rd_miss_cnt), 32'd0);
        @(posedge clk_50); #1;
        bus.bm_ack = 1'b0;
        @(negedge clk_50);
        check("stray_ack_bm_req", 32'(bus.bm_req), 32'd0);
        do_load(32'h100, 0);
        do_load(32'h300, 2);

        // Randomized traffic over a small address set to mix hits, conflicts and stores.
        for (int n = 0; n < 150; n++) begin
            ra = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 2)
               | 32'($urandom_range(0, 3));
            op = $urandom_range(0, 9);
            if (op <= 4)      do_load(ra, $urandom_range(0, 3));
            else if (op <= 7) do_store(1'b0, ra, $urandom, $urandom_range(0, 3));
            else if (op == 8) do_store(1'b1, ra, $urandom, $urandom_range(0, 3));
            else              do_idle();
        end

        // Counter saturation with a narrow counter width.
        for (int n = 0; n < 20; n++) do_load(32'h400, 0);
        for (int n = 0; n < 20; n++) do_load((n % 2 == 0) ? 32'h1400 : 32'h400, 1);
        do_idle();
        check("sat_hit_cnt", 32'(rd_hit_cnt), 32'(CMAX));
        check("sat_miss_cnt", 32'(rd_miss_cnt), 32'(CMAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
